i2c_target_rx: RTL
==================

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 The block SHALL have parameter ADDR, default 7'h40, meaning the 7-bit target address this block acknowledges.
REQ-002 The block SHALL have parameter FILTER_LEN, default 3, meaning the number of consecutive identical samples required for the glitch filter to accept a change (range 2..15).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port scl_i, input, 1 bit: raw I2C SCL from the pad, asynchronous to clk_i.
REQ-006 The block SHALL have port sda_io, inout, 1 bit: I2C SDA, open-drain; the block drives only 1'b0 or 1'bz.
REQ-007 The block SHALL have port start_o, output, 1 bit: one-cycle pulse on each START or repeated START.
REQ-008 The block SHALL have port stop_o, output, 1 bit: one-cycle pulse on each STOP.
REQ-009 The block SHALL have port addr_match_o, output, 1 bit: high from the address ACK until the next START or STOP.
REQ-010 The block SHALL have port rw_o, output, 1 bit: R/W bit of the last matched address byte.
REQ-011 The block SHALL have port data_o, output, 8 bits: last received data byte, MSB first on the wire.
REQ-012 The block SHALL have port data_valid_o, output, 1 bit: one-cycle pulse when data_o is updated.

Function
REQ-013 scl_i and sda_io SHALL each pass through a 2-flop synchronizer, then the glitch filter (REQ-036), giving scl_f and sda_f.
REQ-014 Edges SHALL be detected by comparing scl_f and sda_f with their values one cycle earlier.
REQ-015 START SHALL be flagged when sda_f falls while scl_f is high; STOP when sda_f rises while scl_f is high.
REQ-016 If scl_f and sda_f change in the same cycle, the block SHALL flag no START or STOP and SHALL process only the SCL edge, using the previous sda_f.
REQ-017 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and IGNORE.
REQ-018 START in any state SHALL go to ADDR, clear the bit counter, deassert addr_match_o and pulse start_o.
REQ-019 STOP in any state SHALL go to IDLE, release SDA, deassert addr_match_o and pulse stop_o.
REQ-020 In ADDR and DATA, each scl_f rising edge SHALL shift sda_f into an 8-bit shift register MSB-first and increment a 3-bit counter; the eighth bit wraps the counter to 0.
REQ-021 After 8 ADDR bits, if shift[7:1]==ADDR the FSM SHALL go to ADDR_ACK, latch rw_o=shift[0] and assert addr_match_o; otherwise it SHALL go to IGNORE.
REQ-022 After 8 DATA bits, data_o SHALL load the shift register and data_valid_o SHALL pulse on the next clk cycle, and the FSM SHALL go to DATA_ACK.
REQ-023 In ADDR_ACK and DATA_ACK, SDA SHALL be driven 0 from the first scl_f falling edge until the next scl_f falling edge, then released to z.
REQ-024 On leaving ADDR_ACK, rw_o=0 SHALL go to DATA and rw_o=1 SHALL go to IGNORE (read data comes from a separate transmitter).
REQ-025 On leaving DATA_ACK, the FSM SHALL go to DATA.
REQ-026 IGNORE SHALL leave SDA released and wait for START or STOP.
REQ-027 Bus-edge-to-edge-detect latency SHALL be 2 cycles (synchronizer) plus filter latency.

Reset
REQ-028 On rst_ni low, regardless of clk_i, the FSM SHALL go to IDLE.
REQ-029 On rst_ni low, SDA SHALL be released to z.
REQ-030 On rst_ni low, start_o, stop_o, addr_match_o, rw_o, data_valid_o and data_o SHALL be 0.
REQ-031 On rst_ni low, the synchronizers, filter outputs and previous-value registers SHALL reset to 1 (idle bus), so reset release alone flags no START or STOP.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no data_valid_o pulse.
REQ-033 After reset release, the block SHALL ignore bus activity until the next START.

Configuration
REQ-034 Macro I2C_GLITCH_FILTER_EN SHALL select the filter.
REQ-035 Without I2C_GLITCH_FILTER_EN, scl_f and sda_f SHALL equal the synchronizer outputs (0 extra latency).
REQ-036 With I2C_GLITCH_FILTER_EN defined, scl_f and sda_f SHALL change only after FILTER_LEN consecutive synchronized samples differ from the current value, so pulses shorter than FILTER_LEN cycles are suppressed.

Verification
REQ-037 START, byte 0x80 (addr 0x40, write), byte 0xA5, STOP -> start_o 1 pulse; ACK low on both 9th clocks; data_valid_o 1 pulse, data_o=0xA5; stop_o 1 pulse.
REQ-038 START, address byte 0x82 (addr 0x41) -> no ACK (SDA stays z for the transfer), addr_match_o stays 0, no data_valid_o.
REQ-039 START, 0x80, 0x12, repeated START, 0x81 -> data_o=0x12; second start_o pulse; rw_o=1; ACK on address only; FSM in IGNORE.
REQ-040 With I2C_GLITCH_FILTER_EN, FILTER_LEN=3: 2-cycle low glitch on SCL mid-byte -> bit count unchanged, received byte correct; without the macro, same glitch -> extra shifted bit.
REQ-041 rst_ni pulsed low after 4 data bits -> SDA z, outputs 0, no data_valid_o; following bits ignored until next START.
REQ-042 SCL and SDA toggled in the same clk cycle while SCL high -> neither start_o nor stop_o pulses.

Source files
------------

// File: rtl/i2c_target_rx.sv
// I2C target receiver: detects START/STOP, ACKs its 7-bit address and receives write data.
// Define I2C_GLITCH_FILTER_EN to add a FILTER_LEN-sample glitch filter on SCL/SDA.
module i2c_target_rx #(
    parameter logic [6:0]  ADDR       = 7'h40,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    inout  logic       sda_io,
    output logic       start_o,
    output logic       stop_o,
    output logic       addr_match_o,
    output logic       rw_o,
    output logic [7:0] data_o,
    output logic       data_valid_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;

    state_t     state, state_d;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f, scl_p, sda_p;
    logic [7:0] shift, shift_d;
    logic [2:0] cnt, cnt_d;
    logic       sda_oe, sda_oe_d;
    logic       addr_match_d, rw_d, data_valid_d, start_d, stop_d;
    logic [7:0] data_d;
    logic       scl_rise, scl_fall, scl_chg, sda_chg, start_det, stop_det;

    assign sda_io = sda_oe ? 1'b0 : 1'bz;

    // Synchronizers reset to an idle (high) bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_io};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic       scl_flt, sda_flt;
    logic [3:0] scl_cnt, sda_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_flt <= 1'b1;
            sda_flt <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl_flt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == 4'(FILTER_LEN - 1)) begin
                scl_flt <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
            if (sda_sync[1] == sda_flt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == 4'(FILTER_LEN - 1)) begin
                sda_flt <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end
    end

    assign scl_f = scl_flt;
    assign sda_f = sda_flt;
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    assign scl_chg   = scl_f ^ scl_p;
    assign sda_chg   = sda_f ^ sda_p;
    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    // Simultaneous SCL/SDA changes are treated as a plain SCL edge.
    assign start_det = ~scl_chg & scl_f & sda_chg & ~sda_f;
    assign stop_det  = ~scl_chg & scl_f & sda_chg & sda_f;

    always_comb begin
        state_d      = state;
        shift_d      = shift;
        cnt_d        = cnt;
        sda_oe_d     = sda_oe;
        addr_match_d = addr_match_o;
        rw_d         = rw_o;
        data_d       = data_o;
        data_valid_d = 1'b0;
        start_d      = 1'b0;
        stop_d       = 1'b0;
        if (start_det) begin
            state_d      = ST_ADDR;
            cnt_d        = '0;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            start_d      = 1'b1;
        end else if (stop_det) begin
            state_d      = ST_IDLE;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            stop_d       = 1'b1;
        end else begin
            case (state)
                ST_ADDR, ST_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift[6:0], sda_p};
                        cnt_d   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (state == ST_DATA) begin
                                data_d       = shift_d;
                                data_valid_d = 1'b1;
                                state_d      = ST_DATA_ACK;
                            end else if (shift_d[7:1] == ADDR) begin
                                rw_d         = shift_d[0];
                                addr_match_d = 1'b1;
                                state_d      = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // sda_oe doubles as "first falling edge already seen".
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = (state == ST_ADDR_ACK && rw_o) ? ST_IGNORE : ST_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            scl_p        <= 1'b1;
            sda_p        <= 1'b1;
            shift        <= '0;
            cnt          <= '0;
            sda_oe       <= 1'b0;
            addr_match_o <= 1'b0;
            rw_o         <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            start_o      <= 1'b0;
            stop_o       <= 1'b0;
        end else begin
            state        <= state_d;
            scl_p        <= scl_f;
            sda_p        <= sda_f;
            shift        <= shift_d;
            cnt          <= cnt_d;
            sda_oe       <= sda_oe_d;
            addr_match_o <= addr_match_d;
            rw_o         <= rw_d;
            data_o       <= data_d;
            data_valid_o <= data_valid_d;
            start_o      <= start_d;
            stop_o       <= stop_d;
        end
    end

endmodule
